vreg_i2c_target: RTL and testbench
==================================

Name: vreg_i2c_target

Overview:
Behavioural/synthesizable target side of the voltage-regulator serial control link. It samples the controller's SCL/SDA and decodes the fixed 4-byte write frame: device address, register address, voltage high byte, voltage low byte. It validates and commits the voltage setpoint, then slews a modelled output voltage toward it and reports power-good. It serves as the regulator model in power-subsystem benches and as the front end of an on-die LDO controller.

Parameters:
DEV_ADDR, 8'h60, full first byte that selects this target (8-bit compare, no R/W split)
VREG_ADDR, 8'h02, register address of the voltage setpoint
VMIN_MV, 16'd600, lowest accepted setpoint
VMAX_MV, 16'd1300, highest accepted setpoint
VDEFAULT_MV, 16'd1000, setpoint and output value after reset
SLEW_DIV, 64, clk cycles per slew step (>=1)
SLEW_STEP_MV, 16'd10, maximum mV change per slew step
TIMEOUT_CYC, 20000, clk cycles without a synchronized SCL edge before a mid-frame abort

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
scl_i  in  1  serial clock from controller; asynchronous
sda_i  in  1  serial data; asynchronous, idle high (pull-up). The target never drives SDA: no ACK slot.
vset_mv  out  16  committed setpoint
vout_mv  out  16  modelled output voltage
power_good  out  1  high when vout_mv == vset_mv
write_strobe  out  1  1-cycle pulse when a setpoint is committed
frame_err  out  1  1-cycle pulse on an aborted or rejected frame
range_fault  out  1  sticky; set on an out-of-range setpoint, cleared by the next accepted write

Behaviour:
- Reset values: vset_mv = vout_mv = VDEFAULT_MV; power_good=1; write_strobe=0; frame_err=0; range_fault=0; FSM=IDLE. Synchronizers reset to 1.
- Input path: scl_i and sda_i each pass through a 2-flop synchronizer of equal depth, then one history register (scl_q, sda_q). All decoding uses synchronized values (scl, sda) and their previous values (scl_q, sda_q).
- Event definitions, evaluated every clk:
  - START: sda_q=1 & sda=0 & scl_q=1. Valid even if SCL falls in the same sample.
  - STOP: sda_q=0 & sda=1 & scl_q=1 & scl=1.
  - RISE: scl_q=0 & scl=1. On RISE, the bit is the current sda; SDA changing on the same sample as the SCL rise is legal.
- Priority in one cycle: START > STOP > RISE.
- FSM states: IDLE, RX_ADDR, RX_REG, RX_DHI, RX_DLO, IGNORE. Bytes are shifted MSB first with a 3-bit counter.
  - START in any state: go to RX_ADDR, counter=7, shift register cleared. A START mid-frame is a repeated start and does not pulse frame_err.
  - RX_ADDR, after 8 bits: byte==DEV_ADDR -> RX_REG, else -> IGNORE (no frame_err).
  - RX_REG, after 8 bits: byte==VREG_ADDR -> RX_DHI, else -> IGNORE and pulse frame_err.
  - RX_DHI, after 8 bits: latch the high byte -> RX_DLO.
  - RX_DLO, on the 8th bit, form {hi, lo} and check range:
    - VMIN_MV <= value <= VMAX_MV: vset_mv updates the next cycle, write_strobe pulses that same cycle, range_fault clears.
    - Otherwise: vset_mv is held, range_fault=1, frame_err pulses.
    - Either way the FSM then goes to IGNORE.
  - The commit happens on the last bit. A trailing STOP is not required.
  - IGNORE: discard further bits until START or STOP.
  - STOP in any state -> IDLE. STOP before the frame completes (any state other than IDLE/IGNORE) pulses frame_err; vset_mv is unchanged.
- Timeout: a counter runs while the FSM is in RX_*. It is cleared on every scl edge. At TIMEOUT_CYC the FSM goes to IDLE and frame_err pulses.
- Slew engine, independent of the FSM:
  - A divider counts 0..SLEW_DIV-1 continuously.
  - On wrap, if vout_mv != vset_mv, vout_mv moves toward vset_mv by min(SLEW_STEP_MV, |diff|). Use unsigned 16-bit arithmetic with the compare done before the subtract, so there is no underflow or overshoot.
  - A new setpoint mid-ramp retargets from the current vout_mv.
- power_good is registered: (vout_mv == vset_mv). It drops the cycle after write_strobe if the value changed. A write of the current value keeps power_good high and still pulses write_strobe.
- Async reset mid-frame or mid-ramp restores all reset values immediately.

Decomposition:
- Package vreg_pkg: frame state enum, DEV_ADDR/VREG_ADDR defaults, voltage-level-to-mV table for levels 0..7 (600..1300 in 100 mV steps), shared with the controller and DVFS code.
- Sub-module vreg_slew_model: divider plus vout ramp (inputs vset_mv; outputs vout_mv, power_good), reusable by other regulator models.

Test Plan:
- Proper frame START, 0x60, 0x02, 0x04, 0x4C, STOP -> write_strobe once; vset_mv=1100; vout rises 1000->1100 in 10 steps of 10 mV, one step every 64 cycles; power_good low during the ramp, then high.
- Controller-style frame (SDA and SCL change in the same clk, START with a simultaneous SCL fall, STOP with a simultaneous rise) for 600 mV -> commit on the 32nd bit; vset_mv=600; no frame_err.
- Address 0x62 frame -> no strobe, no frame_err; vset unchanged. Register 0x03 -> frame_err pulse, no strobe.
- Setpoint 1400 -> range_fault=1, frame_err pulse, vset held; a following valid 900 -> range_fault clears, strobe pulses.
- STOP after 20 bits -> frame_err pulse, no commit. SCL frozen mid-byte for TIMEOUT_CYC -> frame_err; the next full frame is accepted.
- 1300 written mid-ramp toward 700 -> vout reverses from its current value without overshoot. rst_n asserted mid-frame -> vset_mv = vout_mv = 1000, power_good=1.

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared definitions for the voltage-regulator control link: frame states,
// default addresses and the voltage-level table used by controller and DVFS code.
package vreg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_REG,
    ST_RX_DHI,
    ST_RX_DLO,
    ST_IGNORE
  } frame_state_e;

  localparam logic [7:0] DEV_ADDR_DEFAULT  = 8'h60;
  localparam logic [7:0] VREG_ADDR_DEFAULT = 8'h02;

  // Levels 0..7 map to 600..1300 mV in 100 mV steps.
  function automatic logic [15:0] level_to_mv(input logic [2:0] level);
    return 16'd600 + 16'(level) * 16'd100;
  endfunction

endpackage

// File: rtl/vreg_slew_model.sv
// Output-voltage ramp model: moves vout_mv toward vset_mv by a bounded step
// once every SLEW_DIV cycles and reports power-good when they match.
module vreg_slew_model #(
  parameter int          SLEW_DIV     = 64,
  parameter logic [15:0] SLEW_STEP_MV = 16'd10,
  parameter logic [15:0] VDEFAULT_MV  = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] vset_mv,
  output logic [15:0] vout_mv,
  output logic        power_good
);

  localparam int DW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DW'(SLEW_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      vout_mv    <= VDEFAULT_MV;
      power_good <= 1'b1;
    end else begin
      div_cnt    <= wrap ? '0 : div_cnt + DW'(1);
      power_good <= (vout_mv == vset_mv);
      // Compare before subtracting so the difference never underflows.
      if (wrap) begin
        if (vout_mv < vset_mv) begin
          vout_mv <= ((vset_mv - vout_mv) > SLEW_STEP_MV) ? vout_mv + SLEW_STEP_MV : vset_mv;
        end else if (vout_mv > vset_mv) begin
          vout_mv <= ((vout_mv - vset_mv) > SLEW_STEP_MV) ? vout_mv - SLEW_STEP_MV : vset_mv;
        end
      end
    end
  end

endmodule

// File: rtl/vreg_i2c_target.sv
// Write-only serial target for the regulator: decodes the 4-byte setpoint
// frame from synchronized SCL/SDA, commits valid setpoints and drives the slew model.
module vreg_i2c_target
  import vreg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR     = DEV_ADDR_DEFAULT,
  parameter logic [7:0]  VREG_ADDR    = VREG_ADDR_DEFAULT,
  parameter logic [15:0] VMIN_MV      = 16'd600,
  parameter logic [15:0] VMAX_MV      = 16'd1300,
  parameter logic [15:0] VDEFAULT_MV  = 16'd1000,
  parameter int          SLEW_DIV     = 64,
  parameter logic [15:0] SLEW_STEP_MV = 16'd10,
  parameter int          TIMEOUT_CYC  = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic [15:0] vset_mv,
  output logic [15:0] vout_mv,
  output logic        power_good,
  output logic        write_strobe,
  output logic        frame_err,
  output logic        range_fault
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]   scl_sync, sda_sync;
  logic         scl, sda, scl_q, sda_q;
  logic         start_ev, stop_ev, rise_ev, scl_edge, in_frame, timeout_hit;
  logic [7:0]   shift_reg, hi_reg, byte_next;
  logic [15:0]  frame_value;
  logic [2:0]   bit_cnt;
  logic [TW-1:0] timeout_cnt;
  frame_state_e state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl;
      sda_q    <= sda;
    end
  end

  assign scl = scl_sync[1];
  assign sda = sda_sync[1];

  assign start_ev    = sda_q && !sda && scl_q;
  assign stop_ev     = !sda_q && sda && scl_q && scl;
  assign rise_ev     = !scl_q && scl;
  assign scl_edge    = scl_q ^ scl;
  assign in_frame    = (state == ST_RX_ADDR) || (state == ST_RX_REG) ||
                       (state == ST_RX_DHI)  || (state == ST_RX_DLO);
  assign timeout_hit = in_frame && !scl_edge && (timeout_cnt == TW'(TIMEOUT_CYC - 1));
  assign byte_next   = {shift_reg[6:0], sda};
  assign frame_value = {hi_reg, byte_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      hi_reg       <= '0;
      bit_cnt      <= 3'd7;
      timeout_cnt  <= '0;
      vset_mv      <= VDEFAULT_MV;
      write_strobe <= 1'b0;
      frame_err    <= 1'b0;
      range_fault  <= 1'b0;
    end else begin
      write_strobe <= 1'b0;
      frame_err    <= 1'b0;
      timeout_cnt  <= (in_frame && !scl_edge) ? timeout_cnt + TW'(1) : '0;

      if (start_ev) begin
        // A repeated start simply restarts the frame; it is not an error.
        state     <= ST_RX_ADDR;
        bit_cnt   <= 3'd7;
        shift_reg <= '0;
      end else if (stop_ev) begin
        state     <= ST_IDLE;
        frame_err <= in_frame;
      end else if (timeout_hit) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end else if (rise_ev && in_frame) begin
        shift_reg <= byte_next;
        bit_cnt   <= bit_cnt - 3'd1;
        if (bit_cnt == 3'd0) begin
          case (state)
            ST_RX_ADDR: state <= (byte_next == DEV_ADDR) ? ST_RX_REG : ST_IGNORE;
            ST_RX_REG: begin
              if (byte_next == VREG_ADDR) begin
                state <= ST_RX_DHI;
              end else begin
                state     <= ST_IGNORE;
                frame_err <= 1'b1;
              end
            end
            ST_RX_DHI: begin
              hi_reg <= byte_next;
              state  <= ST_RX_DLO;
            end
            ST_RX_DLO: begin
              state <= ST_IGNORE;
              if ((frame_value >= VMIN_MV) && (frame_value <= VMAX_MV)) begin
                vset_mv      <= frame_value;
                write_strobe <= 1'b1;
                range_fault  <= 1'b0;
              end else begin
                range_fault <= 1'b1;
                frame_err   <= 1'b1;
              end
            end
            default: state <= ST_IGNORE;
          endcase
        end
      end
    end
  end

  vreg_slew_model #(
    .SLEW_DIV     (SLEW_DIV),
    .SLEW_STEP_MV (SLEW_STEP_MV),
    .VDEFAULT_MV  (VDEFAULT_MV)
  ) u_slew (
    .clk        (clk),
    .rst_n      (rst_n),
    .vset_mv    (vset_mv),
    .vout_mv    (vout_mv),
    .power_good (power_good)
  );

endmodule

// File: tb/tb_vreg_i2c_target.sv
// Bench for vreg_i2c_target: frame vectors, random frames against a rule model,
// and a continuous slew/power-good checker.
module tb_vreg_i2c_target;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_i, sda_i;
  logic [15:0] vset_mv, vout_mv;
  logic        power_good, write_strobe, frame_err, range_fault;

  always #5 clk = ~clk;

  vreg_i2c_target dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .vset_mv      (vset_mv),
    .vout_mv      (vout_mv),
    .power_good   (power_good),
    .write_strobe (write_strobe),
    .frame_err    (frame_err),
    .range_fault  (range_fault)
  );

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int step_cnt = 0;
  int vmin = 65535;

  typedef struct {
    logic [31:0] bytes;
    int          nbits;
    bit          ctl;
    int          vset;
    int          strobes;
    int          errs;
    bit          rf;
    int          steps;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int step_toward(input int cur, input int tgt);
    if (tgt - cur > 10) return cur + 10;
    if (cur - tgt > 10) return cur - 10;
    return tgt;
  endfunction

  // ctl=1: controller style, SDA moves together with SCL edges.
  task automatic send_frame(input logic [31:0] w, input int nbits, input bit ctl, input bit do_stop);
    if (ctl) begin
      sda_i = 1'b1; scl_i = 1'b1; hold(HALF);
      sda_i = 1'b0; scl_i = 1'b0; hold(HALF);
      for (int i = 0; i < nbits; i++) begin
        scl_i = 1'b1; sda_i = w[31-i]; hold(HALF);
        scl_i = 1'b0; hold(HALF);
      end
      if (do_stop) begin
        sda_i = 1'b0; hold(HALF);
        scl_i = 1'b1; sda_i = 1'b1; hold(HALF);
      end
    end else begin
      sda_i = 1'b1; hold(HALF);
      scl_i = 1'b1; hold(HALF);
      sda_i = 1'b0; hold(HALF);
      scl_i = 1'b0; hold(HALF);
      for (int i = 0; i < nbits; i++) begin
        sda_i = w[31-i]; hold(HALF);
        scl_i = 1'b1; hold(HALF);
        scl_i = 1'b0; hold(HALF);
      end
      if (do_stop) begin
        sda_i = 1'b0; hold(HALF);
        scl_i = 1'b1; hold(HALF);
        sda_i = 1'b1; hold(HALF);
      end
    end
    hold(10);
  endtask

  task automatic wait_settle(input int max_cyc);
    int n;
    n = 0;
    while (!((vout_mv == vset_mv) && power_good) && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) begin
      total++;
      bad++;
      $display("FAIL settle: vout=%0d vset=%0d pg=%0d after %0d cycles", vout_mv, vset_mv, power_good, n);
    end
    hold(2);
  endtask

  // Continuous checker: pulse counting, power_good lag, step size and spacing.
  initial begin : monitor
    logic [15:0] pv, ps;
    bit pvalid;
    int cyc, last_chg;
    pvalid = 1'b0;
    cyc = 0;
    last_chg = -1;
    pv = '0;
    ps = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pvalid = 1'b0;
        last_chg = -1;
      end else begin
        if (write_strobe) strobe_cnt++;
        if (frame_err) err_cnt++;
        if (int'(vout_mv) < vmin) vmin = int'(vout_mv);
        if (pvalid) begin
          check("power_good_lag", int'(power_good), int'(pv == ps));
          if (vout_mv != pv) begin
            check("slew_step", int'(vout_mv), step_toward(int'(pv), int'(ps)));
            if (last_chg >= 0) check("slew_spacing", (cyc - last_chg) % 64, 0);
            last_chg = cyc;
            step_cnt++;
          end
        end
        pv = vout_mv;
        ps = vset_mv;
        pvalid = 1'b1;
      end
    end
  end

  int m_vset, m_strobes, m_errs, val;
  bit m_rf;
  logic [7:0] ra, rr;
  logic [15:0] rv;
  bit rc;

  initial begin
    vecs[0] = '{32'h6002044C, 32, 1'b0, 1100, 1, 0, 1'b0, 10};
    vecs[1] = '{32'h60020258, 32, 1'b1,  600, 1, 0, 1'b0, 50};
    vecs[2] = '{32'h620203E8, 32, 1'b0,  600, 0, 0, 1'b0,  0};
    vecs[3] = '{32'h600303E8, 32, 1'b0,  600, 0, 1, 1'b0,  0};
    vecs[4] = '{32'h60020578, 32, 1'b0,  600, 0, 1, 1'b1,  0};
    vecs[5] = '{32'h60020384, 32, 1'b0,  900, 1, 0, 1'b0, 30};
    vecs[6] = '{32'h60020384, 32, 1'b1,  900, 1, 0, 1'b0,  0};
    vecs[7] = '{32'h600203E8, 20, 1'b0,  900, 0, 1, 1'b0,  0};

    rst_n = 1'b0;
    scl_i = 1'b1;
    sda_i = 1'b1;
    hold(3);
    check("reset_vset", int'(vset_mv), 1000);
    check("reset_vout", int'(vout_mv), 1000);
    check("reset_pg", int'(power_good), 1);
    check("reset_strobe", int'(write_strobe), 0);
    check("reset_err", int'(frame_err), 0);
    check("reset_rf", int'(range_fault), 0);
    rst_n = 1'b1;
    hold(5);

    for (int v = 0; v < 8; v++) begin
      strobe_cnt = 0;
      err_cnt = 0;
      step_cnt = 0;
      send_frame(vecs[v].bytes, vecs[v].nbits, vecs[v].ctl, 1'b1);
      wait_settle(6000);
      $display("vec %0d frame=%08h bits=%0d ctl=%0d -> vset=%0d vout=%0d strobes=%0d errs=%0d rf=%0d steps=%0d",
               v, vecs[v].bytes, vecs[v].nbits, vecs[v].ctl, vset_mv, vout_mv, strobe_cnt, err_cnt,
               range_fault, step_cnt);
      check("vec_vset", int'(vset_mv), vecs[v].vset);
      check("vec_strobes", strobe_cnt, vecs[v].strobes);
      check("vec_errs", err_cnt, vecs[v].errs);
      check("vec_range_fault", int'(range_fault), int'(vecs[v].rf));
      check("vec_steps", step_cnt, vecs[v].steps);
      check("vec_vout", int'(vout_mv), vecs[v].vset);
    end

    // SCL frozen low mid-byte until the timeout aborts the frame.
    strobe_cnt = 0;
    err_cnt = 0;
    send_frame(32'h60020320, 12, 1'b0, 1'b0);
    hold(20100);
    $display("timeout: vset=%0d strobes=%0d errs=%0d", vset_mv, strobe_cnt, err_cnt);
    check("timeout_err", err_cnt, 1);
    check("timeout_no_strobe", strobe_cnt, 0);
    check("timeout_vset", int'(vset_mv), 900);
    send_frame(32'h60020320, 32, 1'b0, 1'b1);
    $display("after timeout: vset=%0d strobes=%0d errs=%0d", vset_mv, strobe_cnt, err_cnt);
    check("post_timeout_strobe", strobe_cnt, 1);
    check("post_timeout_vset", int'(vset_mv), 800);
    check("post_timeout_errs", err_cnt, 1);
    wait_settle(6000);

    // Random frames against the decode rules.
    m_vset = 800;
    m_rf = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ra = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h60;
      rr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h02;
      val = int'($urandom_range(400, 1500));
      rv = 16'(val);
      rc = 1'($urandom_range(0, 1));
      m_strobes = 0;
      m_errs = 0;
      if (ra == 8'h60) begin
        if (rr != 8'h02) begin
          m_errs = 1;
        end else if (val >= 600 && val <= 1300) begin
          m_vset = val;
          m_strobes = 1;
          m_rf = 1'b0;
        end else begin
          m_rf = 1'b1;
          m_errs = 1;
        end
      end
      strobe_cnt = 0;
      err_cnt = 0;
      send_frame({ra, rr, rv}, 32, rc, 1'b1);
      $display("rand %0d addr=%02h reg=%02h val=%0d ctl=%0d -> vset=%0d strobes=%0d errs=%0d rf=%0d",
               k, ra, rr, val, rc, vset_mv, strobe_cnt, err_cnt, range_fault);
      check("rand_vset", int'(vset_mv), m_vset);
      check("rand_strobes", strobe_cnt, m_strobes);
      check("rand_errs", err_cnt, m_errs);
      check("rand_rf", int'(range_fault), int'(m_rf));
    end
    wait_settle(8000);
    check("rand_final_vout", int'(vout_mv), m_vset);

    // Retarget mid-ramp: head down toward 700, then reverse to 1300.
    send_frame(32'h600204B0, 32, 1'b0, 1'b1);
    wait_settle(8000);
    send_frame(32'h600202BC, 32, 1'b0, 1'b1);
    hold(300);
    vmin = 65535;
    send_frame(32'h60020514, 32, 1'b0, 1'b1);
    wait_settle(8000);
    $display("reversal: lowest vout=%0d final vout=%0d vset=%0d", vmin, vout_mv, vset_mv);
    check("reversal_mid_ramp", int'((vmin > 700) && (vmin < 1200)), 1);
    check("reversal_final", int'(vout_mv), 1300);

    // Asynchronous reset in the middle of a frame.
    send_frame(32'h600203E8, 12, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    $display("reset mid-frame: vset=%0d vout=%0d pg=%0d", vset_mv, vout_mv, power_good);
    check("midreset_vset", int'(vset_mv), 1000);
    check("midreset_vout", int'(vout_mv), 1000);
    check("midreset_pg", int'(power_good), 1);
    scl_i = 1'b1;
    sda_i = 1'b1;
    hold(3);
    rst_n = 1'b1;
    hold(5);
    strobe_cnt = 0;
    err_cnt = 0;
    send_frame(32'h600203E8, 32, 1'b0, 1'b1);
    $display("after reset: vset=%0d strobes=%0d errs=%0d", vset_mv, strobe_cnt, err_cnt);
    check("post_reset_strobe", strobe_cnt, 1);
    check("post_reset_errs", err_cnt, 0);
    check("post_reset_pg", int'(power_good), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
